aidan_mcnay_prime_sched: RTL and testbench
==========================================

# aidan_mcnay_prime_sched

Trial-division scheduler for the 16-bit prime detector. It accepts a candidate N on a latency-insensitive input stream and drives the shared shift-remainder unit through the sequence N mod 2, N mod 3, N mod 5, N mod 7, … while d·d ≤ N. It returns a prime/composite verdict and the smallest factor on a latency-insensitive output stream. It sits between the top-level candidate source and the remainder unit, and owns that unit's request/response handshake.

## Interface
- nbits, 16: candidate and divisor width; must be even and ≥ 4.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset; synchronous, active-high.
- cand  input  nbits  candidate N.
- istream_val  input  1  cand valid.
- istream_rdy  output  1  block idle and able to accept cand.
- is_prime  output  1  verdict; 1 = prime.
- factor  output  nbits  smallest factor if composite; N if prime; 0 if N < 2.
- ostream_val  output  1  verdict valid.
- ostream_rdy  input  1  consumer accepts verdict.
- div_opa  output  nbits  dividend to remainder unit; always equals latched N.
- div_opb  output  nbits  trial divisor d.
- div_istream_val  output  1  request valid.
- div_istream_rdy  input  1  remainder unit accepts request.
- div_result  input  nbits  div_opa mod div_opb.
- div_ostream_val  input  1  remainder valid.
- div_ostream_rdy  output  1  scheduler accepts remainder.

## Operation
- Registers:
  - n_reg (nbits)
  - d_reg (nbits)
  - sq (2·nbits): equals d·d exactly, either tracked incrementally or computed.
  - is_prime_reg
  - factor_reg
- States: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE:
  - istream_rdy = 1.
  - On istream_val: latch n_reg = cand, set d_reg = 2, clear is_prime_reg and factor_reg.
  - If cand < 2, go to DONE (is_prime = 0, factor = 0). Otherwise go to CHECK.
- CHECK (one cycle):
  - If d·d > n_reg, compared at full 2·nbits width: is_prime = 1, factor = n_reg, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_istream_val = 1, div_opa = n_reg, div_opb = d_reg.
  - div_opa and div_opb are held stable until div_istream_rdy.
  - On div_istream_val && div_istream_rdy, go to WAIT.
- WAIT:
  - div_ostream_rdy = 1.
  - On div_ostream_val: if div_result == 0, set is_prime = 0, factor = d_reg, go to DONE.
  - Otherwise advance d (2 → 3, else d + 2) and go to CHECK.
- DONE:
  - ostream_val = 1; is_prime and factor held stable.
  - On ostream_rdy, go to IDLE.
- Output decoding:
  - istream_rdy = (state == IDLE); ostream_val = (state == DONE).
  - div_istream_val only in ISSUE; div_ostream_rdy only in WAIT.
- Width rules:
  - d never exceeds 2^(nbits/2) + 1, so d + 2 cannot overflow.
  - The d·d comparison never truncates.
- At most one request to the remainder unit is outstanding at any time.
- Requests for one candidate are strictly ascending: 2, 3, 5, 7, 9, …

## Timing
- Reset:
  - Takes effect on the first rising edge with reset = 1, in any state, including mid-request.
  - Resulting values: state = IDLE, istream_rdy = 1, ostream_val = 0, div_istream_val = 0, div_ostream_rdy = 0, is_prime = 0, factor = 0, d_reg = 2.
  - The remainder unit shares clk/reset, so no stale response survives reset.
- Input handshake at edge t moves to CHECK at t+1. For N < 2 it moves to DONE at t+1 instead.
- No-divide latency:
  - N = 2 or 3: ostream_val high from cycle t+2 (CHECK at t+1 finds 4 > N).
  - N < 2: ostream_val high from cycle t+1.
- Per trial divisor: 1 CHECK cycle, then ISSUE for at least 1 cycle, then WAIT for the remainder unit's latency.
- A response is consumed in the same cycle div_ostream_val is seen in WAIT. A verdict is consumed in the same cycle ostream_rdy is seen in DONE.
- A new candidate is accepted no earlier than the cycle after DONE exits. istream_val during non-IDLE states is ignored.
- ostream_rdy held low: DONE holds indefinitely with outputs unchanged.

## Test plan
- N = 0, then N = 1 -> is_prime = 0, factor = 0, ostream_val one cycle after input handshake, zero div_istream_val pulses.
- N = 2, then N = 3 -> is_prime = 1, factor = N, ostream_val two cycles after handshake, no remainder requests.
- N = 9 -> requests exactly (9,2) then (9,3); is_prime = 0, factor = 3. N = 65535 -> single request (65535,3) after (65535,2); factor = 3.
- N = 65521 -> 128 requests (d = 2, 3, 5, …, 255); is_prime = 1, factor = 65521; no request with d = 257.
- Backpressure:
  - div_istream_rdy delayed 5 cycles -> div_opa/div_opb stable throughout.
  - ostream_rdy low 10 cycles -> ostream_val, is_prime, factor unchanged.
  - istream_val pulsed while busy -> ignored.
- Reset asserted during WAIT for N = 65521 -> next edge IDLE with all outputs at reset values; then N = 15 -> factor = 3, is_prime = 0.

Source files
------------

// File: rtl/aidan_mcnay_prime_sched.sv
// Trial-division scheduler for the prime detector: feeds N mod d requests to a
// shared remainder unit for d = 2, 3, 5, 7, ... while d*d <= N, then reports the verdict.
module aidan_mcnay_prime_sched #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [nbits-1:0] cand,
  input  logic             istream_val,
  output logic             istream_rdy,

  output logic             is_prime,
  output logic [nbits-1:0] factor,
  output logic             ostream_val,
  input  logic             ostream_rdy,

  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_istream_val,
  input  logic             div_istream_rdy,

  input  logic [nbits-1:0] div_result,
  input  logic             div_ostream_val,
  output logic             div_ostream_rdy
);

  localparam int SW = 2 * nbits;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;

  logic [nbits-1:0] n_reg;
  logic [nbits-1:0] d_reg;
  logic [SW-1:0]    sq;
  logic             is_prime_reg;
  logic [nbits-1:0] factor_reg;

  logic [nbits-1:0] d_next;
  logic [SW-1:0]    sq_next;
  logic [SW-1:0]    d_wide;
  logic [SW-1:0]    n_wide;
  logic             cand_small;
  logic             sq_exceeds;
  logic             rem_zero;

  // sq tracks d*d incrementally: (d+2)^2 = d^2 + 4d + 4, with the 2 -> 3 step special-cased.
  assign d_wide     = {{nbits{1'b0}}, d_reg};
  assign n_wide     = {{nbits{1'b0}}, n_reg};
  assign d_next     = (d_reg == nbits'(2)) ? nbits'(3) : d_reg + nbits'(2);
  assign sq_next    = (d_reg == nbits'(2)) ? SW'(9) : sq + (d_wide << 2) + SW'(4);
  assign cand_small = (cand < nbits'(2));
  assign sq_exceeds = (sq > n_wide);
  assign rem_zero   = (div_result == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (istream_val) state_next = cand_small ? DONE : CHECK;
      CHECK:   state_next = sq_exceeds ? DONE : ISSUE;
      ISSUE:   if (div_istream_rdy) state_next = WAIT;
      WAIT:    if (div_ostream_val) state_next = rem_zero ? DONE : CHECK;
      DONE:    if (ostream_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg        <= '0;
      d_reg        <= nbits'(2);
      sq           <= SW'(4);
      is_prime_reg <= 1'b0;
      factor_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            n_reg        <= cand;
            d_reg        <= nbits'(2);
            sq           <= SW'(4);
            is_prime_reg <= 1'b0;
            factor_reg   <= '0;
          end
        end
        CHECK: begin
          if (sq_exceeds) begin
            is_prime_reg <= 1'b1;
            factor_reg   <= n_reg;
          end
        end
        WAIT: begin
          if (div_ostream_val) begin
            if (rem_zero) begin
              is_prime_reg <= 1'b0;
              factor_reg   <= d_reg;
            end else begin
              d_reg <= d_next;
              sq    <= sq_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Operands come straight from registers, so they stay stable through ISSUE stalls.
  assign istream_rdy     = (state == IDLE);
  assign ostream_val     = (state == DONE);
  assign div_istream_val = (state == ISSUE);
  assign div_ostream_rdy = (state == WAIT);
  assign div_opa         = n_reg;
  assign div_opb         = d_reg;
  assign is_prime        = is_prime_reg;
  assign factor          = factor_reg;

endmodule

// File: tb/tb_aidan_mcnay_prime_sched.sv
// Bench for aidan_mcnay_prime_sched: a behavioural remainder unit answers requests,
// and a scoreboard of expected verdicts is checked as each verdict is consumed.
module tb_aidan_mcnay_prime_sched;

  typedef struct {
    logic        prime;
    logic [15:0] factor;
    int          reqs;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cand;
  logic        istream_val;
  logic        istream_rdy;
  logic        is_prime;
  logic [15:0] factor;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [15:0] div_opa;
  logic [15:0] div_opb;
  logic        div_istream_val;
  logic        div_istream_rdy;
  logic [15:0] div_result;
  logic        div_ostream_val;
  logic        div_ostream_rdy;

  int n_checks = 0;
  int n_errors = 0;
  sb_item_t scoreboard[$];

  // Shared between the sequencer and the remainder-unit model.
  logic [15:0] cur_n = 16'd0;
  int exp_d = 2;
  int req_count = 0;
  int istall = 0;
  int resp_lat_fixed = -1;

  always #5 clk = ~clk;

  aidan_mcnay_prime_sched #(.nbits(16)) dut (
    .clk(clk), .reset(reset),
    .cand(cand), .istream_val(istream_val), .istream_rdy(istream_rdy),
    .is_prime(is_prime), .factor(factor), .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .div_opa(div_opa), .div_opb(div_opb),
    .div_istream_val(div_istream_val), .div_istream_rdy(div_istream_rdy),
    .div_result(div_result), .div_ostream_val(div_ostream_val), .div_ostream_rdy(div_ostream_rdy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input int n, output sb_item_t it);
    int d;
    it.prime = 1'b0; it.factor = 16'd0; it.reqs = 0;
    if (n >= 2) begin
      it.prime = 1'b1; it.factor = 16'(n);
      d = 2;
      while (d * d <= n) begin
        it.reqs++;
        if (n % d == 0) begin
          it.prime = 1'b0; it.factor = 16'(d);
          break;
        end
        d = (d == 2) ? 3 : d + 2;
      end
    end
  endtask

  // Behavioural remainder unit: optional request stall, then a short response latency.
  initial begin
    int phase = 0;
    int stall_cnt = 0;
    int lat_cnt = 0;
    logic [15:0] hold_a = 16'd0, hold_b = 16'd0;
    div_istream_rdy = 1'b0; div_ostream_val = 1'b0; div_result = 16'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        div_istream_rdy = 1'b0; div_ostream_val = 1'b0;
        phase = 0; stall_cnt = 0;
        continue;
      end
      case (phase)
        0: if (div_istream_val) begin
             if (stall_cnt == 0) begin
               hold_a = div_opa; hold_b = div_opb;
             end else begin
               checkOutput("opa_stable", div_opa, hold_a);
               checkOutput("opb_stable", div_opb, hold_b);
             end
             if (stall_cnt >= istall) begin
               checkOutput("req_opa", div_opa, cur_n);
               checkOutput("req_opb", div_opb, exp_d);
               hold_a = div_opa; hold_b = div_opb;
               req_count++;
               exp_d = (exp_d == 2) ? 3 : exp_d + 2;
               div_istream_rdy = 1'b1;
               stall_cnt = 0;
               phase = 1;
             end else begin
               stall_cnt++;
             end
           end
        1: begin
             div_istream_rdy = 1'b0;
             lat_cnt = (resp_lat_fixed >= 0) ? resp_lat_fixed : int'($urandom_range(0, 2));
             phase = 2;
           end
        2: if (lat_cnt == 0) begin
             checkOutput("div_ostream_rdy", div_ostream_rdy, 1);
             div_result = hold_a % hold_b;
             div_ostream_val = 1'b1;
             phase = 3;
           end else begin
             lat_cnt--;
           end
        default: begin
             div_ostream_val = 1'b0;
             phase = 0;
           end
      endcase
    end
  end

  task automatic applyStimulus(input logic [15:0] n, input int stall, input int hold,
                               input int exp_lat, input bit busy);
    sb_item_t it;
    sb_item_t got;
    int cycles;
    model(int'(n), it);
    scoreboard.push_back(it);
    istall = stall;
    @(negedge clk);
    checkOutput("istream_rdy", istream_rdy, 1);
    cand = n; istream_val = 1'b1;
    cur_n = n; exp_d = 2; req_count = 0;
    @(negedge clk);
    istream_val = 1'b0;
    cycles = 1;
    while (!ostream_val && cycles < 6000) begin
      if (busy) begin
        cand = 16'($urandom); istream_val = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    istream_val = 1'b0;
    checkOutput("ostream_val", ostream_val, 1);
    if (exp_lat > 0) checkOutput("latency", cycles, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_val", ostream_val, 1);
      checkOutput("hold_prime", is_prime, it.prime);
      checkOutput("hold_factor", factor, it.factor);
    end
    ostream_rdy = 1'b1;
    got = scoreboard.pop_front();
    checkOutput("is_prime", is_prime, got.prime);
    checkOutput("factor", factor, got.factor);
    checkOutput("req_count", req_count, got.reqs);
    @(negedge clk);
    ostream_rdy = 1'b0;
    checkOutput("idle_after", istream_rdy, 1);
    checkOutput("val_after", ostream_val, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_istream_rdy"}, istream_rdy, 1);
    checkOutput({tag, "_ostream_val"}, ostream_val, 0);
    checkOutput({tag, "_div_ival"}, div_istream_val, 0);
    checkOutput({tag, "_div_ordy"}, div_ostream_rdy, 0);
    checkOutput({tag, "_is_prime"}, is_prime, 0);
    checkOutput({tag, "_factor"}, factor, 0);
    checkOutput({tag, "_d"}, div_opb, 2);
  endtask

  task automatic applyResetMidWait();
    sb_item_t it;
    int cycles;
    model(65521, it);
    scoreboard.push_back(it);
    istall = 0; resp_lat_fixed = 40;
    @(negedge clk);
    cand = 16'd65521; istream_val = 1'b1;
    cur_n = 16'd65521; exp_d = 2; req_count = 0;
    @(negedge clk);
    istream_val = 1'b0;
    cycles = 0;
    while (!(req_count >= 3 && div_ostream_rdy) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("reached_wait", div_ostream_rdy, 1);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    void'(scoreboard.pop_front());
    @(negedge clk);
    reset = 1'b0;
    resp_lat_fixed = -1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; cand = 16'd0; istream_val = 1'b0; ostream_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;

    applyStimulus(16'd0, 0, 0, 1, 1'b0);
    applyStimulus(16'd1, 0, 0, 1, 1'b0);
    applyStimulus(16'd2, 0, 0, 2, 1'b0);
    applyStimulus(16'd3, 0, 0, 2, 1'b0);
    applyStimulus(16'd9, 0, 0, 0, 1'b0);
    applyStimulus(16'd65535, 0, 0, 0, 1'b0);
    applyStimulus(16'd65521, 0, 0, 0, 1'b0);
    applyStimulus(16'd91, 5, 0, 0, 1'b0);
    applyStimulus(16'd97, 0, 10, 0, 1'b0);
    applyStimulus(16'd221, 0, 0, 0, 1'b1);
    applyResetMidWait();
    applyStimulus(16'd15, 0, 0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(16'($urandom_range(0, 65535)), k % 3, k % 2, 0, k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
